// File: rtl/ram_pkg.sv
// Shared types and constants for the parameterised synchronous RAM and its clear sequencer.
package ram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      RDW_NO_CHANGE   = 2'd0,
      RDW_READ_FIRST  = 2'd1,
      RDW_WRITE_FIRST = 2'd2
   } rdw_mode_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } ram_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sweep: walks every word once, then parks in RUN until the next reset.
//  state    | meaning
//  ST_CLEAR | writing INIT_VALUE to word ptr, ptr advances every cycle
//  ST_RUN   | sweep finished, client port owns the array
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  clr_we_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o,
   output logic                  done_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   ram_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_CLEAR) begin
         ptr_d = ptr_q + ADDR_WIDTH'(1);
         if (ptr_q == LAST_ADDR) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign clr_we_o   = (state_q == ST_CLEAR);
   assign clr_addr_o = ptr_q;
   assign done_o     = (state_q == ST_RUN);

endmodule

// File: rtl/param_sync_ram.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write return,
// 1- or 2-cycle read latency with a valid strobe, and a hardware clear sweep after reset.
module param_sync_ram
   import ram_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 6,
   parameter int                    READ_LATENCY = 1,
   parameter int                    RDW_MODE     = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   din_i,
   output logic                    ready_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    rvalid_o
);

   localparam int        NUM_BYTES = DATA_WIDTH / BYTE_W;
   localparam int        DEPTH     = 1 << ADDR_WIDTH;
   localparam rdw_mode_e MODE      = rdw_mode_e'(RDW_MODE[1:0]);

   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $error("param_sync_ram: READ_LATENCY must be 1 or 2");
   end
   if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
      $error("param_sync_ram: RDW_MODE must be 0, 1 or 2");
   end
   if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
      $error("param_sync_ram: DATA_WIDTH must be a multiple of 8");
   end

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  clr_done;

   ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr),
      .done_o     (clr_done)
   );

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  acc;

   assign acc     = req_i & clr_done;
   assign rd_word = mem_q[addr_i];

   always_comb begin
      wr_word = rd_word;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (be_i[i]) begin
            wr_word[i*BYTE_W +: BYTE_W] = din_i[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Array has no reset; the clear sweep owns the write port until it completes.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= INIT_VALUE;
      end else if (acc && we_i) begin
         mem_q[addr_i] <= wr_word;
      end
   end

   logic                  s1_valid_d, s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;

   assign s1_valid_d = acc & (~we_i | (MODE != RDW_NO_CHANGE));
   assign s1_data_d  = (we_i && MODE == RDW_WRITE_FIRST) ? wr_word : rd_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_valid_d) begin
            s1_data_q <= s1_data_d;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q;
      logic [DATA_WIDTH-1:0] s2_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign rvalid_o = s2_valid_q;
      assign rdata_o  = s2_data_q;
   end else begin : g_lat1
      assign rvalid_o = s1_valid_q;
      assign rdata_o  = s1_data_q;
   end

   assign ready_o = clr_done;

endmodule

// File: tb/tb_param_sync_ram.sv
// Scoreboard bench: three RAM configurations share one stimulus stream and one word-level model.
module tb_param_sync_ram;

   localparam int          DW    = 32;
   localparam int          AW    = 4;
   localparam int          DEPTH = 16;
   localparam int          NI    = 3;
   localparam logic [31:0] INIT  = 32'hA5A5_A5A5;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [3:0]  be    = '0;
   logic [3:0]  addr  = '0;
   logic [31:0] din   = '0;

   logic        ready_w  [NI];
   logic        rvalid_w [NI];
   logic [31:0] rdata_w  [NI];

   always #5 clk = ~clk;

   // instance 0: latency 2, read-first; 1: latency 1, write-first; 2: latency 1, no-change
   param_sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(1),
                    .INIT_VALUE(INIT)) dut_rf (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .din_i(din), .ready_o(ready_w[0]), .rdata_o(rdata_w[0]), .rvalid_o(rvalid_w[0]));

   param_sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(2),
                    .INIT_VALUE(INIT)) dut_wf (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .din_i(din), .ready_o(ready_w[1]), .rdata_o(rdata_w[1]), .rvalid_o(rvalid_w[1]));

   param_sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0),
                    .INIT_VALUE(INIT)) dut_nc (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .din_i(din), .ready_o(ready_w[2]), .rdata_o(rdata_w[2]), .rvalid_o(rvalid_w[2]));

   typedef struct packed {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q [NI][$];
   logic [31:0] model [DEPTH];
   logic [31:0] last_rd [NI];
   int          cyc       = 0;
   int          n_checks  = 0;
   int          n_fail    = 0;
   bit          exp_ready = 1'b0;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int rdw_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every valid pops one expectation; idle cycles must hold rdata
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int k = 0; k < NI; k++) begin
            if (rvalid_w[k]) begin
               if (sb_q[k].size() == 0) begin
                  check($sformatf("unexpected_rvalid[%0d]", k), 32'd1, 32'd0);
               end else begin
                  e = sb_q[k].pop_front();
                  check($sformatf("rdata[%0d]", k), rdata_w[k], e.data);
                  check($sformatf("rvalid_cycle[%0d]", k), cyc, e.due);
               end
               last_rd[k] = rdata_w[k];
            end else begin
               check($sformatf("rdata_hold[%0d]", k), rdata_w[k], last_rd[k]);
            end
         end
      end
   end

   task automatic issue(input bit r, input bit w, input logic [3:0] b, input logic [3:0] a,
                        input logic [31:0] d);
      logic [31:0] pre, post;
      exp_t        e;
      @(negedge clk);
      req = r; we = w; be = b; addr = a; din = d;
      if (r && exp_ready) begin
         pre  = model[a];
         post = pre;
         for (int i = 0; i < 4; i++) if (b[i]) post[8*i +: 8] = d[8*i +: 8];
         for (int k = 0; k < NI; k++) begin
            e.due = cyc + lat_of(k);
            if (!w || rdw_of(k) == 1) begin
               e.data = pre;
               sb_q[k].push_back(e);
            end else if (rdw_of(k) == 2) begin
               e.data = post;
               sb_q[k].push_back(e);
            end
         end
         if (w) model[a] = post;
      end
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("rst_ready[%0d]", k), {31'b0, ready_w[k]}, 32'd0);
         check($sformatf("rst_rvalid[%0d]", k), {31'b0, rvalid_w[k]}, 32'd0);
         check($sformatf("rst_rdata[%0d]", k), rdata_w[k], 32'd0);
         sb_q[k].delete();
         last_rd[k] = '0;
      end
      exp_ready = 1'b0;
      req = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = INIT;
   endtask

   // releases reset and watches ready across the sweep; optional req pokes or early abort
   task automatic sweep_check(input int abort_at, input bit poke);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NI; k++)
         check($sformatf("ready_at_release[%0d]", k), {31'b0, ready_w[k]}, 32'd0);
      for (int s = 1; s <= DEPTH; s++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++)
            check($sformatf("ready_sweep%0d[%0d]", s, k), {31'b0, ready_w[k]},
                  (s == DEPTH) ? 32'd1 : 32'd0);
         if (s == abort_at) begin
            async_reset();
            return;
         end
         if (poke && s < DEPTH) begin
            req = 1'b1; we = 1'($urandom_range(0, 1)); be = 4'($urandom);
            addr = 4'($urandom); din = $urandom;
         end else begin
            req = 1'b0;
         end
      end
      exp_ready = 1'b1;
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) issue(1'b1, 1'b0, 4'($urandom), 4'(a), $urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NI; k++) last_rd[k] = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = INIT;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset_ready[%0d]", k), {31'b0, ready_w[k]}, 32'd0);
         check($sformatf("reset_rvalid[%0d]", k), {31'b0, rvalid_w[k]}, 32'd0);
         check($sformatf("reset_rdata[%0d]", k), rdata_w[k], 32'd0);
      end
      sweep_check(0, 1'b0);
      read_all();

      issue(1'b1, 1'b1, 4'b0101, 4'd3, 32'h1122_3344);
      issue(1'b1, 1'b0, 4'hF, 4'd3, 32'h0);
      idle();

      issue(1'b1, 1'b1, 4'hF, 4'd5, 32'hDEAD_BEEF);
      idle();
      issue(1'b1, 1'b1, 4'hF, 4'd5, 32'h0BAD_F00D);
      repeat (3) idle();
      issue(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);

      issue(1'b1, 1'b1, 4'hF, 4'd2, 32'hCAFE_0002);
      issue(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
      issue(1'b1, 1'b1, 4'h0, 4'd2, 32'hFFFF_FFFF);
      issue(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
      for (int a = 0; a < 8; a++) issue(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);

      for (int i = 0; i < 400; i++)
         issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
               4'($urandom), $urandom);

      async_reset();
      repeat (2) idle();
      sweep_check(0, 1'b1);
      read_all();

      for (int a = 0; a < 4; a++) issue(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
      async_reset();
      idle();
      sweep_check(7, 1'b0);
      repeat (2) idle();
      sweep_check(0, 1'b0);
      read_all();
      for (int i = 0; i < 60; i++)
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               4'($urandom), $urandom);

      repeat (5) idle();
      for (int k = 0; k < NI; k++)
         check($sformatf("drained[%0d]", k), 32'(sb_q[k].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
